yblock_seq_ctrl: RTL and testbench
==================================

Name: yblock_seq_ctrl

Overview:
Sequencer that configures and exercises one 16x16 yblock through its reset, configuration-strobe and input pins.
- Configuration: holds a 16-word configuration buffer written by the host. On command it resets the block and presents each word with a timed strobe.
- Evaluation: applies input vectors, then waits until the block's asynchronous outputs are stable before returning a result.
- Placement: sits between the Wishbone/logic-analyzer host side and the yblock, in place of bench-driven vectors.

Parameters:
NWORDS, 16, number of configuration words (one per row); buffer depth.
RST_CYCLES, 4, cycles blk_reset is held high at the start of configuration.
PHASE_CYCLES, 2, length of each of the SETUP, STROBE and HOLD phases per word; must be at least 1.
STABLE_CYCLES, 3, consecutive unchanged synchronized output samples required to accept a result.
TIMEOUT, 64, maximum APPLY cycles before the result is forced.

Ports:
wb_clk_i  in  1  sole clock.
wb_rst_i  in  1  synchronous reset, active-high.
cfg_we  in  1  write cfg_wdata into buffer[cfg_addr].
cfg_addr  in  4  buffer index.
cfg_wdata  in  16  configuration word.
start  in  1  pulse: begin the reset-plus-configure sequence.
run_go  in  1  pulse: apply run_in to the block.
run_in  in  32  input vector to apply.
busy  out  1  high in RESET, SETUP, STROBE, HOLD and APPLY.
cfg_done  out  1  high in READY and APPLY.
res_valid  out  1  one-cycle pulse when a result is available.
res_data  out  48  captured synchronized block outputs.
res_timeout  out  1  qualifies res_valid: the result was forced by TIMEOUT.
blk_reset  out  1  yblock reset.
blk_cfg_en  out  1  yblock configuration strobe.
blk_hdata  out  16  configuration word presented to the block.
blk_vdata  out  32  block input vector.
blk_out  in  48  asynchronous yblock outputs.

Behaviour:
- Clock and reset: single clock wb_clk_i; wb_rst_i is synchronous, active-high.
- Reset values: state IDLE; all outputs 0; buffer cleared to 0; counters 0.
- Reset during any state returns to IDLE on the next edge. blk_reset goes low; the block is then unconfigured and cfg_done=0.
- Buffer writes: accepted only when busy=0. Writes while busy=1 are dropped.
- Word order: words are presented from index NWORDS-1 down to 0, so word 0 is loaded last.
- IDLE: start -> RESET. run_go is ignored.
- RESET: blk_reset=1 for RST_CYCLES cycles. blk_hdata=0, blk_vdata=0. Then -> SETUP with idx=NWORDS-1.
- SETUP: blk_hdata=buffer[idx], blk_cfg_en=0, for PHASE_CYCLES cycles -> STROBE.
- STROBE: blk_hdata held, blk_cfg_en=1, for PHASE_CYCLES cycles -> HOLD.
- HOLD: blk_hdata held, blk_cfg_en=0, for PHASE_CYCLES cycles.
  - idx>0: decrement idx -> SETUP.
  - idx=0: -> READY with blk_hdata=0.
- Configuration length: total = RST_CYCLES + 3*PHASE_CYCLES*NWORDS cycles from start acceptance to READY entry. Defaults give 100.
- Output hold during configuration: blk_hdata changes only on SETUP entry. blk_cfg_en never rises in the same cycle blk_hdata changes.
- READY:
  - start -> RESET (reconfigure). start has priority if start and run_go arrive in the same cycle.
  - run_go -> APPLY; run_in is registered into blk_vdata on the accepting edge.
- blk_vdata persists after APPLY until the next accepted run_go or reset.
- blk_out path: always passes through a 2-flop synchronizer (sync_out).
- APPLY, start-up: the first 2 cycles are blanking, with no stability counting.
- APPLY, stability counting:
  - stab_cnt increments each cycle sync_out equals its previous value, and resets to 0 on any change.
  - When stab_cnt reaches STABLE_CYCLES: res_valid=1 for one cycle, res_data=sync_out, res_timeout=0, -> READY.
  - Minimum latency with static outputs: res_valid in APPLY cycle 2+STABLE_CYCLES, i.e. 5 cycles after the accepting edge at defaults.
- APPLY, timeout: a timeout counter runs from APPLY entry. At TIMEOUT cycles without stability: res_valid=1, res_timeout=1, res_data=current sync_out, -> READY. Stability takes precedence if both occur in the same cycle.
- APPLY: start and run_go are ignored.
- Result registers: res_data and res_timeout hold their values until the next result or reset.

Test Plan:
- Reset then configure: write buffer[i]=16'h1000+i, pulse start. Check:
  - blk_reset high for exactly 4 cycles.
  - blk_hdata sequence 100F,100E,…,1000, each held 6 cycles, with blk_cfg_en high in cycles 3-4 of each word.
  - READY and cfg_done=1 at cycle 100.
- Write while busy: cfg_we to addr 3 with 16'hBEEF during STROBE. Then reconfigure: word 3 presented with its old value. Write in READY with 16'hBEEF: the next configuration presents BEEF.
- Stable result: in READY, run_in=32'hA5A5_0001, blk_out driven static 48'h0000_1234_5678 -> res_valid at 5 cycles after run_go, res_data=0000_1234_5678, res_timeout=0.
- Oscillation: blk_out toggles bit 0 every cycle -> res_valid at APPLY cycle 64 with res_timeout=1; state returns to READY.
- Priorities: start and run_go in the same READY cycle -> RESET entered, blk_vdata unchanged. run_go in IDLE -> no response.
- Mid-operation reset: assert wb_rst_i during word 7 STROBE -> next cycle all outputs 0, cfg_done=0, buffer reads 0 on a subsequent configure.

Source files
------------

// File: rtl/yblock_seq_ctrl_if.sv
// Host-side bundle for the yblock sequencer: configuration-buffer writes,
// start/run commands and the result/status handshake.
interface yblock_seq_ctrl_if;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        start;
  logic        run_go;
  logic [31:0] run_in;
  logic        busy;
  logic        cfg_done;
  logic        res_valid;
  logic [47:0] res_data;
  logic        res_timeout;

  // Host side: issues commands, observes status and results
  modport master (
    output cfg_we, cfg_addr, cfg_wdata, start, run_go, run_in,
    input  busy, cfg_done, res_valid, res_data, res_timeout
  );

  // Sequencer side
  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, start, run_go, run_in,
    output busy, cfg_done, res_valid, res_data, res_timeout
  );
endinterface

// File: rtl/yblock_seq_ctrl.sv
// Sequencer for one 16x16 yblock: resets the block, loads the configuration
// buffer word by word (highest index first) with a setup/strobe/hold pattern,
// then applies input vectors and returns the block outputs once they have
// settled (or when the settle budget runs out).
module yblock_seq_ctrl #(
  parameter int NWORDS        = 16,
  parameter int RST_CYCLES    = 4,
  parameter int PHASE_CYCLES  = 2,
  parameter int STABLE_CYCLES = 3,
  parameter int TIMEOUT       = 64
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  yblock_seq_ctrl_if.slave       host,
  output logic                   blk_reset,
  output logic                   blk_cfg_en,
  output logic [15:0]            blk_hdata,
  output logic [31:0]            blk_vdata,
  input  logic [47:0]            blk_out
);

  localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RESET  = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
    S_READY  = 3'd5,
    S_APPLY  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        phase_cnt_q, phase_cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        apply_cnt_q, apply_cnt_d;
  logic [15:0]        stab_cnt_q, stab_cnt_d;
  logic [15:0]        buf_q [NWORDS];

  // blk_out is asynchronous to wb_clk_i; sync_out_q is the only version used
  logic [47:0]        sync1_q, sync_out_q, sync_prev_q;

  logic               busy_q, busy_d;
  logic               cfg_done_q, cfg_done_d;
  logic               res_valid_q, res_valid_d;
  logic [47:0]        res_data_q, res_data_d;
  logic               res_timeout_q, res_timeout_d;
  logic               blk_reset_q, blk_reset_d;
  logic               blk_cfg_en_q, blk_cfg_en_d;
  logic [15:0]        blk_hdata_q, blk_hdata_d;
  logic [31:0]        blk_vdata_q, blk_vdata_d;

  // Configuration buffer: host writes land only while the sequencer is not busy
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < NWORDS; i++) begin
        buf_q[i] <= 16'h0000;
      end
    end else if (host.cfg_we && !busy_q && (int'(host.cfg_addr) < NWORDS)) begin
      buf_q[host.cfg_addr[IDX_W-1:0]] <= host.cfg_wdata;
    end
  end

  // Next-state, counters and next values of all registered outputs
  always_comb begin
    state_d       = state_q;
    phase_cnt_d   = phase_cnt_q;
    idx_d         = idx_q;
    apply_cnt_d   = apply_cnt_q;
    stab_cnt_d    = stab_cnt_q;
    res_valid_d   = 1'b0;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    blk_vdata_d   = blk_vdata_q;

    case (state_q)
      S_IDLE: begin
        if (host.start) begin
          state_d     = S_RESET;
          phase_cnt_d = 16'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESET: begin
        if (phase_cnt_q == 16'(RST_CYCLES - 1)) begin
          state_d     = S_SETUP;
          phase_cnt_d = 16'd0;
          idx_d       = IDX_W'(NWORDS - 1);
        end else begin
          phase_cnt_d = phase_cnt_q + 16'd1;
        end
      end
      S_SETUP: begin
        if (phase_cnt_q == 16'(PHASE_CYCLES - 1)) begin
          state_d     = S_STROBE;
          phase_cnt_d = 16'd0;
        end else begin
          phase_cnt_d = phase_cnt_q + 16'd1;
        end
      end
      S_STROBE: begin
        if (phase_cnt_q == 16'(PHASE_CYCLES - 1)) begin
          state_d     = S_HOLD;
          phase_cnt_d = 16'd0;
        end else begin
          phase_cnt_d = phase_cnt_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (phase_cnt_q == 16'(PHASE_CYCLES - 1)) begin
          phase_cnt_d = 16'd0;
          if (idx_q != '0) begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = S_SETUP;
          end else begin
            state_d = S_READY;
          end
        end else begin
          phase_cnt_d = phase_cnt_q + 16'd1;
        end
      end
      S_READY: begin
        // start wins over run_go: reconfiguration leaves blk_vdata untouched
        if (host.start) begin
          state_d     = S_RESET;
          phase_cnt_d = 16'd0;
        end else if (host.run_go) begin
          state_d     = S_APPLY;
          apply_cnt_d = 16'd0;
          stab_cnt_d  = 16'd0;
          blk_vdata_d = host.run_in;
        end else begin
          state_d = S_READY;
        end
      end
      S_APPLY: begin
        apply_cnt_d = apply_cnt_q + 16'd1;
        // First two cycles are blanking while the new vector ripples through
        if (apply_cnt_q >= 16'd2) begin
          if (sync_out_q == sync_prev_q) begin
            stab_cnt_d = stab_cnt_q + 16'd1;
          end else begin
            stab_cnt_d = 16'd0;
          end
        end else begin
          stab_cnt_d = 16'd0;
        end
        // A settled result beats a timeout landing in the same cycle
        if (stab_cnt_d == 16'(STABLE_CYCLES)) begin
          state_d       = S_READY;
          res_valid_d   = 1'b1;
          res_data_d    = sync_out_q;
          res_timeout_d = 1'b0;
        end else if (apply_cnt_q == 16'(TIMEOUT - 1)) begin
          state_d       = S_READY;
          res_valid_d   = 1'b1;
          res_data_d    = sync_out_q;
          res_timeout_d = 1'b1;
        end else begin
          state_d = S_APPLY;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d       = (state_d == S_RESET) || (state_d == S_SETUP) || (state_d == S_STROBE) ||
                   (state_d == S_HOLD)  || (state_d == S_APPLY);
    cfg_done_d   = (state_d == S_READY) || (state_d == S_APPLY);
    blk_reset_d  = (state_d == S_RESET);
    blk_cfg_en_d = (state_d == S_STROBE);
    // idx only moves on HOLD->SETUP and the buffer is frozen while busy,
    // so the presented word changes only on SETUP entry
    if ((state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD)) begin
      blk_hdata_d = buf_q[idx_d];
    end else begin
      blk_hdata_d = 16'h0000;
    end
  end

  // State, counters, synchronizer and registered outputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= S_IDLE;
      phase_cnt_q   <= 16'd0;
      idx_q         <= '0;
      apply_cnt_q   <= 16'd0;
      stab_cnt_q    <= 16'd0;
      sync1_q       <= 48'd0;
      sync_out_q    <= 48'd0;
      sync_prev_q   <= 48'd0;
      busy_q        <= 1'b0;
      cfg_done_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      res_data_q    <= 48'd0;
      res_timeout_q <= 1'b0;
      blk_reset_q   <= 1'b0;
      blk_cfg_en_q  <= 1'b0;
      blk_hdata_q   <= 16'h0000;
      blk_vdata_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      phase_cnt_q   <= phase_cnt_d;
      idx_q         <= idx_d;
      apply_cnt_q   <= apply_cnt_d;
      stab_cnt_q    <= stab_cnt_d;
      sync1_q       <= blk_out;
      sync_out_q    <= sync1_q;
      sync_prev_q   <= sync_out_q;
      busy_q        <= busy_d;
      cfg_done_q    <= cfg_done_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
      blk_reset_q   <= blk_reset_d;
      blk_cfg_en_q  <= blk_cfg_en_d;
      blk_hdata_q   <= blk_hdata_d;
      blk_vdata_q   <= blk_vdata_d;
    end
  end

  assign host.busy        = busy_q;
  assign host.cfg_done    = cfg_done_q;
  assign host.res_valid   = res_valid_q;
  assign host.res_data    = res_data_q;
  assign host.res_timeout = res_timeout_q;
  assign blk_reset        = blk_reset_q;
  assign blk_cfg_en       = blk_cfg_en_q;
  assign blk_hdata        = blk_hdata_q;
  assign blk_vdata        = blk_vdata_q;

endmodule

// File: tb/tb_yblock_seq_ctrl.sv
// Directed bench for yblock_seq_ctrl: configuration traces, write dropping,
// stable/timeout results via a scoreboard, command priorities and reset.
module tb_yblock_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        blk_reset;
  logic        blk_cfg_en;
  logic [15:0] blk_hdata;
  logic [31:0] blk_vdata;
  logic [47:0] blk_out_s;

  yblock_seq_ctrl_if host_if ();

  yblock_seq_ctrl dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .host       (host_if.slave),
    .blk_reset  (blk_reset),
    .blk_cfg_en (blk_cfg_en),
    .blk_hdata  (blk_hdata),
    .blk_vdata  (blk_vdata),
    .blk_out    (blk_out_s)
  );

  typedef struct {
    int          cyc;
    logic [47:0] data;
    logic        to;
  } exp_t;

  exp_t        sb_q [$];
  int          n_asserts = 0;
  int          n_fail    = 0;
  int          cyc       = 0;
  logic [15:0] exp_buf [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Result monitor: every res_valid pulse must match the oldest expectation
  exp_t e;
  always @(negedge clk) begin
    if (host_if.res_valid === 1'b1) begin
      chk("res_valid_expected", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("res_cycle", 64'(cyc), 64'(e.cyc));
        chk("res_data", 64'(host_if.res_data), 64'(e.data));
        chk("res_timeout", 64'(host_if.res_timeout), 64'(e.to));
      end
    end
  end

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    host_if.cfg_we    = 1'b1;
    host_if.cfg_addr  = a;
    host_if.cfg_wdata = d;
    @(negedge clk);
    host_if.cfg_we    = 1'b0;
  endtask

  // Pulse start, then check every cycle of the 100-cycle configuration
  task automatic run_config(input bit inject);
    logic [19:0] expv;
    int j;
    host_if.start = 1'b1;
    @(negedge clk);
    host_if.start = 1'b0;
    for (int k = 0; k <= 100; k++) begin
      if (k > 0) @(negedge clk);
      if (inject && k == 36) begin
        host_if.cfg_we    = 1'b1;
        host_if.cfg_addr  = 4'd3;
        host_if.cfg_wdata = 16'hBEEF;
      end else begin
        host_if.cfg_we = 1'b0;
      end
      if (k < 4) begin
        expv = {1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
      end else if (k < 100) begin
        j = k - 4;
        expv = {1'b0, ((j % 6) == 2 || (j % 6) == 3), exp_buf[15 - j / 6], 1'b1, 1'b0};
      end else begin
        expv = {1'b0, 1'b0, 16'h0000, 1'b0, 1'b1};
      end
      chk($sformatf("cfg_k%0d", k),
          64'({blk_reset, blk_cfg_en, blk_hdata, host_if.busy, host_if.cfg_done}), 64'(expv));
    end
  endtask

  initial begin
    int c;
    rst               = 1'b1;
    host_if.cfg_we    = 1'b0;
    host_if.cfg_addr  = 4'd0;
    host_if.cfg_wdata = 16'h0000;
    host_if.start     = 1'b0;
    host_if.run_go    = 1'b0;
    host_if.run_in    = 32'd0;
    blk_out_s         = 48'h0000_1234_5678;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_host", 64'({host_if.busy, host_if.cfg_done, host_if.res_valid,
                            host_if.res_timeout, host_if.res_data}), 64'd0);
    chk("reset_blk", 64'({blk_reset, blk_cfg_en, blk_hdata, blk_vdata}), 64'd0);

    // Fill buffer and configure, attempting a write during word 10 STROBE
    for (int i = 0; i < 16; i++) begin
      exp_buf[i] = 16'h1000 + 16'(i);
      wr(4'(i), 16'h1000 + 16'(i));
    end
    run_config(1'b1);
    run_config(1'b0);
    wr(4'd3, 16'hBEEF);
    exp_buf[3] = 16'hBEEF;
    run_config(1'b0);

    // Stable result
    c = cyc;
    host_if.run_in = 32'hA5A5_0001;
    host_if.run_go = 1'b1;
    sb_q.push_back('{c + 6, 48'h0000_1234_5678, 1'b0});
    @(negedge clk);
    host_if.run_go = 1'b0;
    chk("apply_entry", 64'({host_if.busy, host_if.cfg_done, blk_vdata}), 64'({2'b11, 32'hA5A5_0001}));
    repeat (8) @(negedge clk);
    chk("stable_back_ready", 64'({host_if.busy, host_if.cfg_done, host_if.res_valid}), 64'({3'b010}));
    chk("res_data_hold", 64'({host_if.res_timeout, host_if.res_data}), 64'({1'b0, 48'h0000_1234_5678}));

    // Oscillating outputs force a timeout result
    c = cyc;
    host_if.run_in = 32'h0000_0002;
    host_if.run_go = 1'b1;
    blk_out_s      = 48'hC0DE_0000_F0F0;
    sb_q.push_back('{c + 65, 48'hC0DE_0000_F0F0, 1'b1});
    for (int j = 1; j <= 70; j++) begin
      @(negedge clk);
      host_if.run_go = 1'b0;
      blk_out_s[0]   = ~blk_out_s[0];
    end
    blk_out_s = 48'hC0DE_0000_F0F0;
    chk("timeout_back_ready", 64'({host_if.busy, host_if.cfg_done, blk_vdata}), 64'({2'b01, 32'h0000_0002}));

    // start and run_go together: start wins, vector untouched
    host_if.start  = 1'b1;
    host_if.run_go = 1'b1;
    host_if.run_in = 32'hDEAD_BEEF;
    @(negedge clk);
    host_if.start  = 1'b0;
    host_if.run_go = 1'b0;
    chk("prio_reset", 64'({blk_reset, host_if.busy, host_if.cfg_done, blk_vdata}), 64'({3'b110, 32'h0000_0002}));
    repeat (100) @(negedge clk);
    chk("prio_ready", 64'({host_if.busy, host_if.cfg_done, blk_vdata}), 64'({2'b01, 32'h0000_0002}));

    // run_go in IDLE is ignored
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    host_if.run_in = 32'h0000_1234;
    host_if.run_go = 1'b1;
    @(negedge clk);
    host_if.run_go = 1'b0;
    repeat (8) @(negedge clk);
    chk("idle_run_go", 64'({host_if.busy, host_if.cfg_done, blk_vdata}), 64'd0);

    // Reset during word 7 STROBE
    for (int i = 0; i < 16; i++) wr(4'(i), 16'h1000 + 16'(i));
    host_if.start = 1'b1;
    @(negedge clk);
    host_if.start = 1'b0;
    repeat (54) @(negedge clk);
    chk("word7_strobe", 64'({blk_cfg_en, blk_hdata}), 64'({1'b1, 16'h1007}));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_host", 64'({host_if.busy, host_if.cfg_done, host_if.res_valid,
                             host_if.res_timeout, host_if.res_data}), 64'd0);
    chk("midrst_blk", 64'({blk_reset, blk_cfg_en, blk_hdata, blk_vdata}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) exp_buf[i] = 16'h0000;
    run_config(1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
